dbus_mem_responder: RTL

//   Data-bus responder: answers dbus_req_t requests from the memory stage with dbus_resp_t.

---
 rtl/dbus_mem_responder_pkg.sv | 33 +++
 rtl/dbus_mem_responder_strobe_ram.sv | 29 ++
 rtl/dbus_mem_responder.sv | 106 ++++++++++
 3 files changed

// File: rtl/dbus_mem_responder_pkg.sv
// dbus_mem_responder_pkg: data-bus request/response types shared by the memory stage and its responders
//   msize_t     access size code (carried on the bus, ignored by the responder)
//   strobe_t    per-byte write enables, bit i covers data[8i+7:8i]
//   dbus_req_t  valid, addr, size, strobe, data
//   dbus_resp_t addr_ok, data_ok, data
package dbus_mem_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    localparam dbus_resp_t DBUS_RESP_IDLE = '0;

endpackage

// File: rtl/dbus_mem_responder_strobe_ram.sv
// strobe_ram: single-port 64-bit RAM with byte enables, registered read, read-before-write
//   clk    in  rising-edge clock
//   rd     in  load rdata from mem[addr]; rdata holds otherwise
//   be     in  byte write enables into mem[addr]
//   addr   in  word index
//   wdata  in  write data
//   rdata  out registered read data
module strobe_ram
    import dbus_mem_responder_pkg::*;
#(
    parameter int WORDS = 4096
) (
    input  logic                     clk,
    input  logic                     rd,
    input  strobe_t                  be,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [63:0]              wdata,
    output logic [63:0]              rdata
);

    logic [63:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (rd) rdata <= mem[addr];
        for (int i = 0; i < 8; i++)
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end

endmodule

// File: rtl/dbus_mem_responder.sv
// dbus_mem_responder: fixed-latency data-bus responder backed by a byte-enabled 64-bit RAM
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset
//   dreq     in  request from the memory stage (sampled only while idle)
//   dresp    out handshake (addr_ok/data_ok together, one cycle) and read data
//   oob_err  out pulses with the handshake of an out-of-range access
module dbus_mem_responder
    import dbus_mem_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       oob_err
);

    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [63:0] SPAN     = 64'(MEM_WORDS) << 3;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        cap;
    logic [63:0] req_addr, req_data;
    strobe_t     req_strobe;
    logic [63:0] cur_addr, off, rdata;
    logic        in_range, rd;
    strobe_t     be;
    logic        ok_q, oob_q, rdv_q;
    logic        unused_bits;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cap     = 1'b0;
        case (state)
            IDLE: if (dreq.valid) begin
                cap     = 1'b1;
                state_d = (LATENCY == 1) ? RESP : WAIT;
                cnt_d   = CNT_INIT;
            end
            WAIT: begin
                cnt_d   = cnt - 4'd1;
                state_d = (cnt == 4'd1) ? RESP : WAIT;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In IDLE the RAM read may be issued straight from the bus (LATENCY=1), otherwise from the latch.
    assign cur_addr = (state == IDLE) ? dreq.addr : req_addr;
    // Subtract-then-compare keeps the upper bound check free of overflow near the top of the space.
    assign off      = cur_addr - BASE_ADDR;
    assign in_range = (cur_addr >= BASE_ADDR) && (off < SPAN);
    // The read is issued on the edge entering RESP so the word is in rdata during RESP.
    assign rd       = (state_d == RESP);
    // The write lands at the end of RESP, after the pre-write word was already read.
    assign be       = (state == RESP && in_range) ? req_strobe : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req_addr   <= '0;
            req_data   <= '0;
            req_strobe <= '0;
            ok_q       <= 1'b0;
            oob_q      <= 1'b0;
            rdv_q      <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (cap) begin
                req_addr   <= dreq.addr;
                req_data   <= dreq.data;
                req_strobe <= dreq.strobe;
            end
            ok_q  <= rd;
            oob_q <= rd && !in_range;
            if (rd) rdv_q <= in_range;
        end
    end

    strobe_ram #(.WORDS(MEM_WORDS)) u_ram (
        .clk   (clk),
        .rd    (rd),
        .be    (be),
        .addr  (off[AW+2:3]),
        .wdata (req_data),
        .rdata (rdata)
    );

    // rdv_q masks the RAM word to zero after reset and for out-of-range responses, and holds with rdata.
    assign dresp   = '{addr_ok: ok_q, data_ok: ok_q, data: rdv_q ? rdata : 64'd0};
    assign oob_err = oob_q;

    assign unused_bits = ^{dreq.size, off[63:AW+3], off[2:0]};

endmodule
